// File: rtl/eth_pkg.sv
// ============================================================================
// eth_pkg: shared Ethernet TX constants, scheduler state encoding and defaults.
// Revision: 1.0
// ============================================================================
`default_nettype none

package eth_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] PAD_BYTE      = 8'h00;

    localparam int DEFAULT_PREAMBLE_LEN = 7;
    localparam int DEFAULT_MIN_PAYLOAD  = 60;
    localparam int DEFAULT_IPG_CYCLES   = 48;

    localparam int BYTE_CNT_W = 11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PAD      = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_PREAMBLE = ST_PREAMBLE,
        S_DATA     = ST_DATA,
        S_PAD      = ST_PAD,
        S_DRAIN    = ST_DRAIN,
        S_GAP      = ST_GAP
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2: two-way round-robin grant, frozen while hold is asserted.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic       clk,
    input  logic       sresetn,
    input  logic [1:0] req,
    input  logic       hold,
    output logic       grant
);

    logic last_grant;
    logic winner;

    // On a tie the source that did not win last time goes next.
    always_comb begin
        winner = (req == 2'b11) ? ~last_grant : req[1];
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else if (!hold && (req != 2'b00)) begin
            grant      <= winner;
            last_grant <= winner;
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_tx_scheduler.sv
// ============================================================================
// eth_tx_scheduler: two-source frame scheduler adding preamble/SFD, padding
// short frames and spacing frames by the inter-packet gap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN,
    parameter int MIN_PAYLOAD  = DEFAULT_MIN_PAYLOAD,
    parameter int IPG_CYCLES   = DEFAULT_IPG_CYCLES
) (
    input  logic       clk,
    input  logic       sresetn,
    input  logic       s0_axis_tvalid,
    output logic       s0_axis_tready,
    input  logic [7:0] s0_axis_tdata,
    input  logic       s0_axis_tlast,
    input  logic       s1_axis_tvalid,
    output logic       s1_axis_tready,
    input  logic [7:0] s1_axis_tdata,
    input  logic       s1_axis_tlast,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       grant,
    output logic       tx_underrun
);

    localparam int PRE_W = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
    localparam int GAP_W = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PREAMBLE_LEN);
    localparam logic [PRE_W-1:0]      PRE_ONE  = PRE_W'(1);
    localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
    // The IDLE arbitration cycle is the final cycle of the gap.
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'((IPG_CYCLES > 2) ? IPG_CYCLES - 2 : 0);
    localparam logic [BYTE_CNT_W:0]   CNT_ONE  = (BYTE_CNT_W+1)'(1);
    localparam logic [BYTE_CNT_W:0]   MIN_PAY  = (BYTE_CNT_W+1)'(MIN_PAYLOAD);

    tx_state_t              state;
    logic [PRE_W-1:0]       pre_cnt;
    logic [BYTE_CNT_W-1:0]  byte_cnt;
    logic [GAP_W-1:0]       gap_cnt;

    logic                   sel_valid;
    logic [7:0]             sel_data;
    logic                   sel_last;
    logic [BYTE_CNT_W:0]    cnt_plus;
    logic [BYTE_CNT_W-1:0]  cnt_sat;
    logic                   payload_done;
    logic                   underrun;
    logic                   data_xfer;
    logic                   src_ready;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .sresetn (sresetn),
        .req     ({s1_axis_tvalid, s0_axis_tvalid}),
        .hold    (state != S_IDLE),
        .grant   (grant)
    );

    always_comb begin
        sel_valid    = grant ? s1_axis_tvalid : s0_axis_tvalid;
        sel_data     = grant ? s1_axis_tdata  : s0_axis_tdata;
        sel_last     = grant ? s1_axis_tlast  : s0_axis_tlast;
        cnt_plus     = {1'b0, byte_cnt} + CNT_ONE;
        cnt_sat      = cnt_plus[BYTE_CNT_W] ? byte_cnt : cnt_plus[BYTE_CNT_W-1:0];
        payload_done = (cnt_plus >= MIN_PAY);
        underrun     = (state == S_DATA) && m_axis_tready && !sel_valid;
        data_xfer    = (state == S_DATA) && m_axis_tready && sel_valid;
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = PAD_BYTE;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        tx_underrun   = 1'b0;
        src_ready     = 1'b0;
        case (state)
            S_PREAMBLE: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = (pre_cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            S_DATA: begin
                m_axis_tvalid = 1'b1;
                if (underrun) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tuser = 1'b1;
                    tx_underrun  = 1'b1;
                end else begin
                    m_axis_tdata = sel_data;
                    m_axis_tlast = sel_valid && sel_last && payload_done;
                end
                // Ready is withheld on the aborted beat so no source byte is lost.
                src_ready = m_axis_tready && sel_valid;
            end
            S_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = payload_done;
            end
            S_DRAIN: begin
                src_ready = 1'b1;
            end
            default: begin
            end
        endcase
        s0_axis_tready = src_ready && !grant;
        s1_axis_tready = src_ready && grant;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state    <= S_IDLE;
            pre_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state != S_GAP) begin
                gap_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    pre_cnt <= '0;
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        state <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (m_axis_tready) begin
                        if (pre_cnt == PRE_LAST) begin
                            state    <= S_DATA;
                            byte_cnt <= '0;
                        end else begin
                            pre_cnt <= pre_cnt + PRE_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (underrun) begin
                        state <= S_DRAIN;
                    end else if (data_xfer) begin
                        byte_cnt <= cnt_sat;
                        if (sel_last) begin
                            state <= payload_done ? S_GAP : S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (m_axis_tready) begin
                        byte_cnt <= cnt_sat;
                        if (payload_done) begin
                            state <= S_GAP;
                        end
                    end
                end
                S_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
